// File: rtl/core_pht.sv
// Gshare pattern history table: 2-bit counters indexed by fetch PC xor speculative
// global history, trained at resolve, with mispredict/flush history recovery.
module core_pht #(
  parameter int unsigned GHR_WIDTH = 8,
  parameter int unsigned PHT_DEPTH = 256,
  parameter logic [1:0]  CNT_INIT  = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc,
  input  logic                 pred_branch,
  output logic                 PHT_pred_taken,
  output logic [GHR_WIDTH-1:0] pred_index,
  output logic [GHR_WIDTH-1:0] pred_ghr,
  input  logic                 update_valid,
  input  logic [GHR_WIDTH-1:0] update_index,
  input  logic                 update_taken,
  input  logic                 update_mispred,
  input  logic [GHR_WIDTH-1:0] update_ghr,
  input  logic                 flush,
  output logic [15:0]          mispred_cnt
);

  localparam int unsigned CNT_W  = 2;
  localparam int unsigned MCNT_W = 16;

  logic [CNT_W-1:0]     cnt_q [PHT_DEPTH];
  logic [CNT_W-1:0]     cnt_d [PHT_DEPTH];
  logic [GHR_WIDTH-1:0] spec_ghr_q, spec_ghr_d;
  logic [GHR_WIDTH-1:0] arch_ghr_q, arch_ghr_d;
  logic [MCNT_W-1:0]    mispred_cnt_q, mispred_cnt_d;
  logic [GHR_WIDTH-1:0] lookup_index;
  logic [CNT_W-1:0]     upd_cnt;
  logic                 lookup_taken;
  logic                 mispred_evt;

  // PC bits outside the index window are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[31:GHR_WIDTH+2], pc[1:0]};

  // Combinational lookup; reads the pre-update counter (read-before-write).
  always_comb begin
    lookup_index = pc[GHR_WIDTH+1:2] ^ spec_ghr_q;
    lookup_taken = cnt_q[lookup_index][1];
  end

  assign PHT_pred_taken = lookup_taken;
  assign pred_index     = lookup_index;
  assign pred_ghr       = spec_ghr_q;
  assign mispred_cnt    = mispred_cnt_q;

  // Counter training, history update and mispredict accounting.
  always_comb begin
    cnt_d         = cnt_q;
    arch_ghr_d    = arch_ghr_q;
    spec_ghr_d    = spec_ghr_q;
    mispred_cnt_d = mispred_cnt_q;
    upd_cnt       = cnt_q[update_index];
    mispred_evt   = update_valid && update_mispred;

    if (update_valid) begin
      if (update_taken) begin
        if (upd_cnt != 2'b11) begin
          cnt_d[update_index] = upd_cnt + CNT_W'(1);
        end
      end else if (upd_cnt != 2'b00) begin
        cnt_d[update_index] = upd_cnt - CNT_W'(1);
      end
      arch_ghr_d = {arch_ghr_q[GHR_WIDTH-2:0], update_taken};
    end

    // Recovery beats flush, which beats a speculative lookup shift.
    if (mispred_evt) begin
      spec_ghr_d = {update_ghr[GHR_WIDTH-2:0], update_taken};
    end else if (flush) begin
      spec_ghr_d = arch_ghr_d;
    end else if (pred_branch) begin
      spec_ghr_d = {spec_ghr_q[GHR_WIDTH-2:0], lookup_taken};
    end

    if (mispred_evt && (mispred_cnt_q != {MCNT_W{1'b1}})) begin
      mispred_cnt_d = mispred_cnt_q + MCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        cnt_q[i] <= CNT_INIT;
      end
      spec_ghr_q    <= '0;
      arch_ghr_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      spec_ghr_q    <= spec_ghr_d;
      arch_ghr_q    <= arch_ghr_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_core_pht.sv
// Self-checking bench for core_pht: directed vectors, hand-written corner sequences
// and randomized traffic compared against an arithmetic gshare model.
module tb_core_pht;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pred_branch;
  logic        PHT_pred_taken;
  logic [7:0]  pred_index;
  logic [7:0]  pred_ghr;
  logic        update_valid;
  logic [7:0]  update_index;
  logic        update_taken;
  logic        update_mispred;
  logic [7:0]  update_ghr;
  logic        flush;
  logic [15:0] mispred_cnt;

  core_pht dut (
    .clk(clk), .rst(rst), .pc(pc), .pred_branch(pred_branch),
    .PHT_pred_taken(PHT_pred_taken), .pred_index(pred_index), .pred_ghr(pred_ghr),
    .update_valid(update_valid), .update_index(update_index), .update_taken(update_taken),
    .update_mispred(update_mispred), .update_ghr(update_ghr), .flush(flush),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integers, updated from the behavioural rules.
  int m_cnt [256];
  int m_spec, m_arch, m_mcnt;

  typedef struct {
    logic       uv;
    logic       ut;
    logic       exp_taken;
    logic [7:0] exp_index;
    logic [7:0] exp_ghr;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 256; i++) m_cnt[i] = 1;
    m_spec = 0;
    m_arch = 0;
    m_mcnt = 0;
  endtask

  // Apply inputs and compare the same-cycle outputs with the model.
  task automatic drive_check(input logic uv, input logic [7:0] uidx, input logic ut,
                             input logic um, input logic [7:0] ughr, input logic pb,
                             input logic fl, input logic [31:0] p);
    int idx;
    update_valid = uv; update_index = uidx; update_taken = ut; update_mispred = um;
    update_ghr = ughr; pred_branch = pb; flush = fl; pc = p;
    #1;
    idx = ((p >> 2) & 255) ^ m_spec;
    chk("taken", PHT_pred_taken, (m_cnt[idx] >= 2) ? 1 : 0);
    chk("index", pred_index, idx);
    chk("ghr", pred_ghr, m_spec);
    chk("mcnt", mispred_cnt, m_mcnt);
  endtask

  // Clock edge, then advance the model using the inputs that were sampled.
  task automatic advance();
    int idx, pt, new_arch;
    idx = ((pc >> 2) & 255) ^ m_spec;
    pt  = (m_cnt[idx] >= 2) ? 1 : 0;
    @(posedge clk);
    new_arch = m_arch;
    if (update_valid) begin
      new_arch = (m_arch * 2 + update_taken) % 256;
      if (update_taken) m_cnt[update_index] = (m_cnt[update_index] < 3) ? m_cnt[update_index] + 1 : 3;
      else              m_cnt[update_index] = (m_cnt[update_index] > 0) ? m_cnt[update_index] - 1 : 0;
    end
    if (update_valid && update_mispred) begin
      m_spec = (update_ghr * 2 + update_taken) % 256;
      if (m_mcnt < 65535) m_mcnt++;
    end else if (flush) begin
      m_spec = new_arch;
    end else if (pred_branch) begin
      m_spec = (m_spec * 2 + pt) % 256;
    end
    m_arch = new_arch;
    #1;
  endtask

  task automatic step(input logic uv, input logic [7:0] uidx, input logic ut,
                      input logic um, input logic [7:0] ughr, input logic pb,
                      input logic fl, input logic [31:0] p);
    drive_check(uv, uidx, ut, um, ughr, pb, fl, p);
    advance();
  endtask

  initial begin
    // Counter 0x10 walk: 1->2->3->3, then down to 0 and held, then one taken.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'h10, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h10, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h10, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h10, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h10, 8'h00};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h00};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h00};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h10, 8'h00};

    rst = 1'b0; pc = 32'h0000_0040; pred_branch = 1'b0; update_valid = 1'b0;
    update_index = 8'h00; update_taken = 1'b0; update_mispred = 1'b0;
    update_ghr = 8'h00; flush = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_taken", PHT_pred_taken, 0);
    chk("rst_index", pred_index, 8'h10);
    chk("rst_ghr", pred_ghr, 0);
    chk("rst_mcnt", mispred_cnt, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Saturation table, same index as the lookup (read-before-write).
    for (int i = 0; i < 11; i++) begin
      drive_check(tbl[i].uv, 8'h10, tbl[i].ut, 1'b0, 8'h00, 1'b0, 1'b0, 32'h40);
      chk("tbl_taken", PHT_pred_taken, tbl[i].exp_taken);
      chk("tbl_index", pred_index, tbl[i].exp_index);
      chk("tbl_ghr", pred_ghr, tbl[i].exp_ghr);
      advance();
    end

    // Mispredict recovery with a colliding lookup shift.
    step(1'b1, 8'h20, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 32'h40);
    chk("recov_ghr", pred_ghr, 8'h79);
    chk("recov_mcnt", mispred_cnt, 1);

    // Asynchronous reset mid-cycle discards history at once.
    rst = 1'b0;
    #1;
    chk("async_ghr", pred_ghr, 0);
    chk("async_mcnt", mispred_cnt, 0);
    m_reset();
    #2;
    rst = 1'b1;

    // Speculative shifts with predictions 1, 0, 1.
    step(1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h40);
    step(1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h40);
    step(1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h40);
    step(1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h40);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h40);
    #1;
    chk("shift_ghr", pred_ghr, 8'h05);
    chk("shift_index", pred_index, 8'h15);

    // Flush together with an update uses the post-update architectural history.
    step(1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 32'h40);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h30, (i == 0), 1'b0, 8'h00, 1'b0, 1'b0, 32'h40);
    chk("pre_flush_ghr", pred_ghr, 8'h79);
    step(1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h40);
    chk("flush_ghr", pred_ghr, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h40);
    chk("flush_arch", pred_ghr, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), $urandom);
    end

    // Mispredict counter saturation.
    for (int i = 0; i < 65540; i++) begin
      step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 8'($urandom),
           1'b0, 1'b0, $urandom);
    end
    chk("mcnt_sat", mispred_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
